// File: rtl/cas_pkg.sv
// Shared types and helpers for the continuous-assignment sampler.
package cas_pkg;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} cas_state_t;

    // Width of a counter that must hold 0..window inclusive.
    function automatic int cnt_w(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/cas_history.sv
// DEPTH-entry shift register of {net, var} samples, newest at index 0,
// with a combinational read port.
module cas_history
    import cas_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     shift,
    input  logic [WIDTH-1:0]         net_in,
    input  logic [WIDTH-1:0]         var_in,
    input  logic [$clog2(DEPTH)-1:0] hist_idx,
    output logic [WIDTH-1:0]         hist_net,
    output logic [WIDTH-1:0]         hist_var
);

    logic [DEPTH-1:0][WIDTH-1:0] net_q;
    logic [DEPTH-1:0][WIDTH-1:0] var_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [WIDTH-1:0] net_d;
        logic [WIDTH-1:0] var_d;

        if (i == 0) begin : g_head
            assign net_d = net_in;
            assign var_d = var_in;
        end else begin : g_tail
            assign net_d = net_q[i-1];
            assign var_d = var_q[i-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                net_q[i] <= '0;
                var_q[i] <= '0;
            end else if (clr) begin
                net_q[i] <= '0;
                var_q[i] <= '0;
            end else if (shift) begin
                net_q[i] <= net_d;
                var_q[i] <= var_d;
            end
        end
    end

    // Indices past the last entry (non power-of-two DEPTH) read as zero.
    always_comb begin
        hist_net = '0;
        hist_var = '0;
        if (int'(hist_idx) < DEPTH) begin
            hist_net = net_q[hist_idx];
            hist_var = var_q[hist_idx];
        end
    end

endmodule

// File: rtl/cont_assign_sampler.sv
// Samples net- and variable-path copies of one stimulus over a fixed window,
// counts changes per path and timestamps the first disagreement.
// Optional history capture is enabled with `define CAS_HISTORY_EN (needs DEPTH >= 2).
module cont_assign_sampler
    import cas_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int WINDOW = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           net_in,
    input  logic [WIDTH-1:0]           var_in,
    output logic                       busy,
    output logic                       done,
    output logic                       mismatch,
    output logic [cnt_w(WINDOW)-1:0]   first_mm_idx,
    output logic [cnt_w(WINDOW)-1:0]   net_chg_cnt,
    output logic [cnt_w(WINDOW)-1:0]   var_chg_cnt
`ifdef CAS_HISTORY_EN
    ,
    input  logic [$clog2(DEPTH)-1:0]   hist_idx,
    output logic [WIDTH-1:0]           hist_net,
    output logic [WIDTH-1:0]           hist_var
`endif
);

    localparam int                 CNT_W   = cnt_w(WINDOW);
    localparam logic [CNT_W-1:0]   ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   LAST    = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   NO_MM   = CNT_W'(WINDOW);

    cas_state_t       state;
    logic [CNT_W-1:0] cyc;
    logic [WIDTH-1:0] prev_net;
    logic [WIDTH-1:0] prev_var;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
            first_mm_idx <= '0;
            net_chg_cnt  <= '0;
            var_chg_cnt  <= '0;
            cyc          <= '0;
            prev_net     <= '0;
            prev_var     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    net_chg_cnt  <= '0;
                    var_chg_cnt  <= '0;
                    mismatch     <= 1'b0;
                    first_mm_idx <= NO_MM;
                    cyc          <= '0;
                    prev_net     <= net_in;
                    prev_var     <= var_in;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    if (net_in != prev_net) net_chg_cnt <= net_chg_cnt + ONE;
                    if (var_in != prev_var) var_chg_cnt <= var_chg_cnt + ONE;
                    prev_net <= net_in;
                    prev_var <= var_in;
                    // Only the first disagreement in the window is timestamped.
                    if (net_in != var_in) begin
                        mismatch <= 1'b1;
                        if (!mismatch) first_mm_idx <= cyc;
                    end
                    cyc <= cyc + ONE;
                    if (cyc == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAS_HISTORY_EN
    cas_history #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_history (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == ARM),
        .shift    (state == CAPTURE),
        .net_in   (net_in),
        .var_in   (var_in),
        .hist_idx (hist_idx),
        .hist_net (hist_net),
        .hist_var (hist_var)
    );
`else
    // History depth has no meaning without the history store.
    if (DEPTH < 1) begin : g_depth_unused
    end
`endif

endmodule

// File: tb/tb_cont_assign_sampler.sv
// Self-checking bench for cont_assign_sampler: directed vector table, random
// windows against a reference model, and multi-cycle corner sequences.
module tb_cont_assign_sampler;
    import cas_pkg::*;

    localparam int W   = 4;
    localparam int WIN = 16;
    localparam int DEP = 8;
    localparam int CW  = cnt_w(WIN);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  net_in = '0;
    logic [W-1:0]  var_in = '0;
    logic          busy, done, mismatch;
    logic [CW-1:0] first_mm_idx, net_chg_cnt, var_chg_cnt;
`ifdef CAS_HISTORY_EN
    logic [$clog2(DEP)-1:0] hist_idx = '0;
    logic [W-1:0]           hist_net, hist_var;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    // Index 0 is the value presented during ARM, 1..WIN the capture cycles.
    logic [W-1:0] net_seq [0:WIN];
    logic [W-1:0] var_seq [0:WIN];

    typedef struct {
        string          name;
        logic [W-1:0]   base;
        bit             toggle;
        logic [WIN-1:0] diff_mask;
        logic [W-1:0]   flip;
        int             e_net;
        int             e_var;
        int             e_mm;
        int             e_first;
    } vec_t;

    vec_t vecs [6];

    cont_assign_sampler #(
        .WIDTH  (W),
        .WINDOW (WIN),
        .DEPTH  (DEP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .net_in       (net_in),
        .var_in       (var_in),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .first_mm_idx (first_mm_idx),
        .net_chg_cnt  (net_chg_cnt),
        .var_chg_cnt  (var_chg_cnt)
`ifdef CAS_HISTORY_EN
        ,
        .hist_idx     (hist_idx),
        .hist_net     (hist_net),
        .hist_var     (hist_var)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string pfx, input int e_net, input int e_var,
                           input int e_mm, input int e_first);
        chk({pfx, "_net_cnt"}, int'(net_chg_cnt), e_net);
        chk({pfx, "_var_cnt"}, int'(var_chg_cnt), e_var);
        chk({pfx, "_mismatch"}, int'(mismatch), e_mm);
        chk({pfx, "_first_mm"}, int'(first_mm_idx), e_first);
    endtask

    task automatic load_vec(input vec_t v);
        net_seq[0] = v.base;
        var_seq[0] = v.base;
        for (int c = 0; c < WIN; c++) begin
            net_seq[c+1] = (v.toggle && (c % 2 == 0)) ? ~v.base : v.base;
            var_seq[c+1] = v.diff_mask[c] ? (net_seq[c+1] ^ v.flip) : net_seq[c+1];
        end
    endtask

    // Reference: count changes against the previous sample, first differing cycle.
    task automatic model(output int e_net, output int e_var, output int e_mm,
                         output int e_first);
        e_net = 0;
        e_var = 0;
        e_first = WIN;
        for (int c = 1; c <= WIN; c++) begin
            if (net_seq[c] != net_seq[c-1]) e_net++;
            if (var_seq[c] != var_seq[c-1]) e_var++;
            if (net_seq[c] != var_seq[c] && e_first == WIN) e_first = c - 1;
        end
        e_mm = (e_first != WIN) ? 1 : 0;
    endtask

    // One full window from IDLE; optional start pokes in CAPTURE and DONE.
    task automatic run_win(input string pfx, input bit poke);
        int lat;
        start  = 1'b1;
        net_in = net_seq[0];
        var_in = var_seq[0];
        @(posedge clk); #1;
        start = 1'b0;
        chk({pfx, "_busy_arm"}, int'(busy), 1);
        for (int c = 0; c < WIN; c++) begin
            @(posedge clk); #1;
            net_in = net_seq[c+1];
            var_in = var_seq[c+1];
            start  = poke && (c == 3);
        end
        start = 1'b0;
        lat = WIN;
        while (!done && lat < WIN + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({pfx, "_done_latency"}, lat, WIN + 1);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({pfx, "_done_width"}, int'(done), 0);
        chk({pfx, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        int e_net, e_var, e_mm, e_first;
        int snap, busy_seen;
        int done_t [$];

        vecs[0] = '{"toggle_both", 4'h5, 1'b1, 16'h0000, 4'h0, 16, 16, 0, 16};
        vecs[1] = '{"var_flip_5_9", 4'hA, 1'b0, 16'h0220, 4'h1, 0, 4, 1, 5};
        vecs[2] = '{"bit2_cyc0", 4'h3, 1'b0, 16'h0001, 4'h4, 0, 2, 1, 0};
        vecs[3] = '{"last_cyc", 4'h9, 1'b0, 16'h8000, 4'hF, 0, 1, 1, 15};
        vecs[4] = '{"toggle_all_diff", 4'h6, 1'b1, 16'hFFFF, 4'h2, 16, 16, 1, 0};
        vecs[5] = '{"toggle_diff3", 4'h0, 1'b1, 16'h0008, 4'h8, 16, 16, 1, 3};

        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_first_mm", int'(first_mm_idx), 0);
        chk("rst_net_cnt", int'(net_chg_cnt), 0);
        chk("rst_var_cnt", int'(var_chg_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            load_vec(vecs[i]);
            run_win(vecs[i].name, 1'b0);
            chk_res(vecs[i].name, vecs[i].e_net, vecs[i].e_var, vecs[i].e_mm, vecs[i].e_first);
        end

        for (int r = 0; r < 8; r++) begin
            net_seq[0] = W'($urandom);
            var_seq[0] = ($urandom_range(0, 3) == 0) ? W'($urandom) : net_seq[0];
            for (int c = 1; c <= WIN; c++) begin
                net_seq[c] = ($urandom_range(0, 2) == 0) ? W'($urandom) : net_seq[c-1];
                var_seq[c] = ($urandom_range(0, 5) == 0) ? W'($urandom) : net_seq[c];
            end
            model(e_net, e_var, e_mm, e_first);
            run_win("rand", 1'b0);
            chk_res("rand", e_net, e_var, e_mm, e_first);
        end

        // Start pulses in CAPTURE and DONE are dropped, results hold in IDLE.
        load_vec(vecs[1]);
        snap = done_cnt;
        run_win("poke", 1'b1);
        chk_res("poke", 0, 4, 1, 5);
        busy_seen = 0;
        for (int t = 0; t < 25; t++) begin
            @(posedge clk); #1;
            if (busy) busy_seen++;
        end
        chk("poke_done_count", done_cnt - snap, 1);
        chk("poke_no_rearm", busy_seen, 0);
        chk_res("poke_hold", 0, 4, 1, 5);

        // Reset during CAPTURE cycle 7 aborts without a done pulse.
        load_vec(vecs[4]);
        start  = 1'b1;
        net_in = net_seq[0];
        var_in = var_seq[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk); #1;
            net_in = net_seq[c+1];
            var_in = var_seq[c+1];
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk_res("midrst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        snap = done_cnt;
        busy_seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (busy) busy_seen++;
        end
        chk("midrst_no_done", done_cnt - snap, 0);
        chk("midrst_idle", busy_seen, 0);
        load_vec(vecs[0]);
        run_win("post_rst", 1'b0);
        chk_res("post_rst", 16, 16, 0, 16);

        // Start held high re-arms every WINDOW+3 cycles.
        net_in = '0;
        var_in = '0;
        start  = 1'b1;
        for (int t = 0; t < 3 * (WIN + 3) + 4; t++) begin
            @(posedge clk); #1;
            if (done) done_t.push_back(t);
        end
        start = 1'b0;
        chk("cont_done_pulses", done_t.size(), 3);
        for (int i = 1; i < done_t.size(); i++)
            chk("cont_period", done_t[i] - done_t[i-1], WIN + 3);
        for (int t = 0; t < 2 * (WIN + 3); t++) begin
            @(posedge clk); #1;
        end
        chk("cont_idle", int'(busy), 0);

`ifdef CAS_HISTORY_EN
        net_seq[0] = '0;
        var_seq[0] = '1;
        for (int c = 0; c < WIN; c++) begin
            net_seq[c+1] = W'(c);
            var_seq[c+1] = ~W'(c);
        end
        run_win("hist", 1'b0);
        hist_idx = 0;
        #1;
        chk("hist0_net", int'(hist_net), 15);
        chk("hist0_var", int'(hist_var), 0);
        hist_idx = 7;
        #1;
        chk("hist7_net", int'(hist_net), 8);
        chk("hist7_var", int'(hist_var), 7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
